// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps a registered NCO divider from a start value to a stop
// value in fixed increments, holding each value for a programmable dwell.
// Optional feature macro NCO_SWEEP_BIDIR_EN adds the cfg_bidir input: when it
// is latched high, the sweep turns around at stop and runs back to start.
module nco_sweep_ctrl #(
   parameter int DIV_W   = 16,
   parameter int DWELL_W = 24,
   parameter int RST_DIV = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [DIV_W-1:0]   cfg_start_div,
   input  logic [DIV_W-1:0]   cfg_stop_div,
   input  logic [DIV_W-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic               cfg_repeat,
`ifdef NCO_SWEEP_BIDIR_EN
   input  logic               cfg_bidir,
`endif
   output logic [DIV_W-1:0]   nco_div,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      STEP  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [DIV_W-1:0]   div_nxt;
   logic [DIV_W-1:0]   start_q;
   logic [DIV_W-1:0]   start_nxt;
   logic [DIV_W-1:0]   stop_q;
   logic [DIV_W-1:0]   stop_nxt;
   logic [DIV_W-1:0]   step_q;
   logic [DIV_W-1:0]   step_nxt;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_nxt;
   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_nxt;
   logic [DWELL_W-1:0] dwell_eff;
   logic               repeat_q;
   logic               repeat_nxt;
   logic               up_q;
   logic               up_nxt;
   logic               done_nxt;
   logic               returning;
   logic               reverse_now;
   logic [DIV_W-1:0]   target;
   logic               going_up;

   // Move cur one step toward tgt, landing exactly on tgt on overshoot,
   // wrap-around or a zero step.
   function automatic logic [DIV_W-1:0] advance(
      input logic [DIV_W-1:0] cur,
      input logic [DIV_W-1:0] tgt,
      input logic [DIV_W-1:0] stp,
      input logic             up
   );
      logic [DIV_W:0]   wide;
      logic [DIV_W-1:0] res;
      if (up) begin
         wide = {1'b0, cur} + {1'b0, stp};
         res  = (stp == '0 || wide[DIV_W] || wide[DIV_W-1:0] > tgt) ? tgt : wide[DIV_W-1:0];
      end else begin
         wide = {1'b0, cur} - {1'b0, stp};
         res  = (stp == '0 || wide[DIV_W] || wide[DIV_W-1:0] < tgt) ? tgt : wide[DIV_W-1:0];
      end
      return res;
   endfunction

   assign busy      = (state != IDLE);
   assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
   assign target    = returning ? start_q : stop_q;
   assign going_up  = up_q ^ returning;

`ifdef NCO_SWEEP_BIDIR_EN
   logic bidir_q;
   logic bidir_nxt;
   logic returning_nxt;

   // Latched bidirectional mode and which half of the round trip is active.
   always_ff @(posedge clk) begin
      if (rst) begin
         bidir_q   <= 1'b0;
         returning <= 1'b0;
      end else begin
         bidir_q   <= bidir_nxt;
         returning <= returning_nxt;
      end
   end

   assign reverse_now = bidir_q && !returning && (start_q != stop_q);
`else
   assign returning   = 1'b0;
   assign reverse_now = 1'b0;
`endif

   // State, divider, dwell counter and shadow configuration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         nco_div  <= DIV_W'(RST_DIV);
         cnt_q    <= '0;
         start_q  <= '0;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         repeat_q <= 1'b0;
         up_q     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         nco_div  <= div_nxt;
         cnt_q    <= cnt_nxt;
         start_q  <= start_nxt;
         stop_q   <= stop_nxt;
         step_q   <= step_nxt;
         dwell_q  <= dwell_nxt;
         repeat_q <= repeat_nxt;
         up_q     <= up_nxt;
         done     <= done_nxt;
      end
   end

   // Next-state logic: accept a sweep, count the dwell, then advance or finish.
   always_comb begin
      state_nxt  = state;
      div_nxt    = nco_div;
      cnt_nxt    = cnt_q;
      start_nxt  = start_q;
      stop_nxt   = stop_q;
      step_nxt   = step_q;
      dwell_nxt  = dwell_q;
      repeat_nxt = repeat_q;
      up_nxt     = up_q;
      done_nxt   = 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      bidir_nxt     = bidir_q;
      returning_nxt = returning;
`endif
      case (state)
         IDLE: begin
            if (start && !abort) begin
               start_nxt  = cfg_start_div;
               stop_nxt   = cfg_stop_div;
               step_nxt   = cfg_step;
               dwell_nxt  = cfg_dwell;
               repeat_nxt = cfg_repeat;
               up_nxt     = (cfg_stop_div >= cfg_start_div);
               div_nxt    = cfg_start_div;
               cnt_nxt    = DWELL_W'(1);
               state_nxt  = DWELL;
`ifdef NCO_SWEEP_BIDIR_EN
               bidir_nxt     = cfg_bidir;
               returning_nxt = 1'b0;
`endif
            end
         end
         DWELL: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (cnt_q >= dwell_eff) begin
               state_nxt = STEP;
            end else begin
               cnt_nxt = cnt_q + DWELL_W'(1);
            end
         end
         STEP: begin
            cnt_nxt = DWELL_W'(1);
            if (abort) begin
               state_nxt = IDLE;
            end else if (nco_div != target) begin
               div_nxt   = advance(nco_div, target, step_q, going_up);
               state_nxt = DWELL;
            end else if (reverse_now) begin
               div_nxt   = advance(nco_div, start_q, step_q, !up_q);
               state_nxt = DWELL;
`ifdef NCO_SWEEP_BIDIR_EN
               returning_nxt = 1'b1;
`endif
            end else if (repeat_q) begin
               div_nxt   = start_q;
               state_nxt = DWELL;
`ifdef NCO_SWEEP_BIDIR_EN
               returning_nxt = 1'b0;
`endif
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed sweeps against a value-list model of the
// sweep controller, compared cycle by cycle on the falling clock edge.
module tb_nco_sweep_ctrl;

   localparam int RST_DIV = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] cfg_start_div;
   logic [15:0] cfg_stop_div;
   logic [15:0] cfg_step;
   logic [23:0] cfg_dwell;
   logic        cfg_repeat;
`ifdef NCO_SWEEP_BIDIR_EN
   logic        cfg_bidir;
`endif
   logic [15:0] nco_div;
   logic        busy;
   logic        done;

   nco_sweep_ctrl #(
      .DIV_W   (16),
      .DWELL_W (24),
      .RST_DIV (RST_DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .cfg_start_div (cfg_start_div),
      .cfg_stop_div  (cfg_stop_div),
      .cfg_step      (cfg_step),
      .cfg_dwell     (cfg_dwell),
      .cfg_repeat    (cfg_repeat),
`ifdef NCO_SWEEP_BIDIR_EN
      .cfg_bidir     (cfg_bidir),
`endif
      .nco_div       (nco_div),
      .busy          (busy),
      .done          (done)
   );

   // 100 MHz bench clock.
   always #5 clk = ~clk;

   typedef struct {
      int div;
      bit busy;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   int   idle_div;
   bit   check_en;
   int   n_compared;
   int   n_mismatched;
   int   mvals[$];
   int   cyc_vals[$];

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int move_toward(input int v, input int tgt, input int st);
      if (st == 0) return tgt;
      if (tgt >= v) return (v + st > tgt) ? tgt : v + st;
      return (v - st < tgt) ? tgt : v - st;
   endfunction

   // Ordered list of distinct divider values a sweep visits.
   task automatic model_values(input int s, input int e, input int st, input bit bidir);
      int v;
      int guard;
      mvals.delete();
      v = s;
      mvals.push_back(v);
      guard = 0;
      while (v != e && guard < 70000) begin
         v = move_toward(v, e, st);
         mvals.push_back(v);
         guard++;
      end
      if (bidir && s != e) begin
         while (v != s && guard < 140000) begin
            v = move_toward(v, s, st);
            mvals.push_back(v);
            guard++;
         end
      end
   endtask

   // Expand the value list into one entry per busy clock; limit 0 means whole sweep once.
   task automatic build_cycles(input int dwell, input bit rep, input int limit);
      int hold;
      bit more;
      hold = ((dwell == 0) ? 1 : dwell) + 1;
      cyc_vals.delete();
      more = 1'b1;
      while (more) begin
         foreach (mvals[i]) begin
            for (int h = 0; h < hold; h++) cyc_vals.push_back(mvals[i]);
         end
         more = rep && (limit > 0) && (cyc_vals.size() < limit);
      end
      if (limit > 0) begin
         while (cyc_vals.size() > limit) void'(cyc_vals.pop_back());
      end
   endtask

   // Compare every cycle against the queued expectation, or the idle state when empty.
   always @(negedge clk) begin
      exp_t e;
      if (check_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e.div  = idle_div;
            e.busy = 1'b0;
            e.done = 1'b0;
         end
         checkOutput("nco_div", int'(nco_div), e.div);
         checkOutput("busy", int'(busy), int'(e.busy));
         checkOutput("done", int'(done), int'(e.done));
      end
   end

   task automatic applyStimulus(input int s, input int e, input int st, input int dw,
                                input bit rep, input bit bidir);
      cfg_start_div = 16'(s);
      cfg_stop_div  = 16'(e);
      cfg_step      = 16'(st);
      cfg_dwell     = 24'(dw);
      cfg_repeat    = rep;
`ifdef NCO_SWEEP_BIDIR_EN
      cfg_bidir     = bidir;
`else
      if (bidir) $display("[TB] bidir request ignored in this build");
`endif
      start = 1'b1;
   endtask

   // mode 0: run to completion; mode 1: abort in busy cycle k; mode 2: reset in busy cycle k.
   task automatic runSweep(input int s, input int e, input int st, input int dw, input bit rep,
                           input bit bidir, input int mode, input int k, input bit poke);
      exp_t x;
      int   guard;
      model_values(s, e, st, bidir);
      build_cycles(dw, rep, (mode == 0) ? 0 : k + 1);
      x.div = idle_div; x.busy = 1'b0; x.done = 1'b0;
      exp_q.push_back(x);
      foreach (cyc_vals[i]) begin
         x.div = cyc_vals[i]; x.busy = 1'b1; x.done = 1'b0;
         exp_q.push_back(x);
      end
      if (mode == 0) begin
         x.div = mvals[mvals.size() - 1]; x.busy = 1'b0; x.done = 1'b1;
         exp_q.push_back(x);
         idle_div = x.div;
      end else if (mode == 1) begin
         idle_div = cyc_vals[cyc_vals.size() - 1];
      end else begin
         idle_div = RST_DIV;
      end

      applyStimulus(s, e, st, dw, rep, bidir);
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 0 && poke) begin
         @(posedge clk); #1;
         cfg_start_div = 16'($urandom);
         cfg_stop_div  = 16'($urandom);
         cfg_step      = 16'($urandom);
         cfg_dwell     = 24'($urandom_range(0, 5));
         cfg_repeat    = 1'b1;
         start         = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end else if (mode == 1) begin
         repeat (k) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
      end else if (mode == 2) begin
         repeat (k) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk); #1;
         start = 1'b1;
         @(posedge clk); #1;
         rst   = 1'b0;
         start = 1'b0;
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL sweep_timeout: %0d entries left, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pinList(input string name, input int want[]);
      checkOutput({name, "_len"}, mvals.size(), want.size());
      foreach (want[i]) begin
         if (i < mvals.size()) checkOutput(name, mvals[i], want[i]);
      end
   endtask

   initial begin
      int want34[];
      int want35[];
      int want37[];
      int want39[];
      n_compared    = 0;
      n_mismatched  = 0;
      check_en      = 1'b0;
      idle_div      = RST_DIV;
      rst           = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      cfg_start_div = '0;
      cfg_stop_div  = '0;
      cfg_step      = '0;
      cfg_dwell     = '0;
      cfg_repeat    = 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      cfg_bidir     = 1'b0;
`endif

      // Hand-computed value lists that pin the model itself.
      want34 = '{100, 110, 120, 130};
      want35 = '{130, 105, 100};
      want37 = '{65530, 65535};
      want39 = '{10, 20, 30, 20, 10};
      model_values(100, 130, 10, 1'b0);
      pinList("model_up", want34);
      build_cycles(3, 1'b0, 0);
      checkOutput("model_up_cycles", cyc_vals.size(), 16);
      model_values(130, 100, 25, 1'b0);
      pinList("model_down", want35);
      model_values(65530, 65535, 10, 1'b0);
      pinList("model_ovf", want37);
      model_values(10, 30, 10, 1'b1);
      pinList("model_bidir", want39);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_div", int'(nco_div), RST_DIV);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      check_en = 1'b1;

      // start together with abort in IDLE must be ignored
      cfg_start_div = 16'd500;
      cfg_stop_div  = 16'd600;
      cfg_step      = 16'd50;
      cfg_dwell     = 24'd1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      runSweep(100, 130, 10, 3, 1'b0, 1'b0, 0, 0, 1'b1);
      runSweep(130, 100, 25, 1, 1'b0, 1'b0, 0, 0, 1'b1);
      runSweep(16, 48, 16, 2, 1'b1, 1'b0, 1, 4, 1'b0);
      runSweep(16, 48, 16, 2, 1'b1, 1'b0, 1, 13, 1'b0);
      runSweep(65530, 65535, 10, 2, 1'b0, 1'b0, 0, 0, 1'b1);
      runSweep(100, 130, 10, 3, 1'b0, 1'b0, 2, 6, 1'b0);
      runSweep(200, 50, 0, 2, 1'b0, 1'b0, 0, 0, 1'b0);
      runSweep(77, 77, 5, 0, 1'b0, 1'b0, 0, 0, 1'b1);
      runSweep(300, 100, 50, 2, 1'b0, 1'b0, 1, 2, 1'b0);
      runSweep(20, 0, 30, 1, 1'b0, 1'b0, 0, 0, 1'b0);
`ifdef NCO_SWEEP_BIDIR_EN
      runSweep(10, 30, 10, 1, 1'b0, 1'b1, 0, 0, 1'b1);
`endif
      runSweep(1000, 1003, 1, 0, 1'b0, 1'b0, 0, 0, 1'b0);

      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
